// File: rtl/seg7_serial_tx.sv
// seg7_serial_tx: shifts a WIDTH-bit segment pattern MSB-first into the
// external seven-segment shift-register chain over a 4-wire bus
// sout = {sclk, sclrn, sdat, spen}.
//
// The block uses a start/busy/done handshake. sclk is generated from clk,
// with each sclk half-period lasting CLK_DIV clk cycles.
//
// Optional feature: define SEG7_TX_CHANGE_DETECT_EN to start a transfer
// automatically, without a start pulse, whenever pdata differs from the
// pattern last sent.
module seg7_serial_tx #(
  parameter int WIDTH   = 64,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       sout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {ST_IDLE,  ST_SHIFT} state_e;
  typedef enum logic {PH_LOW,   PH_HIGH}  phase_e;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic              sclk_q, sclk_d;
  logic              sclrn_q, sclrn_d;
  logic              sdat_q, sdat_d;
  logic              spen_q, spen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              req;
  logic              tick;
  logic              last_fall;

`ifdef SEG7_TX_CHANGE_DETECT_EN
  logic [WIDTH-1:0]  last_sent_q, last_sent_d;

  // A changed pattern acts like an implicit start request.
  assign req = start | (pdata != last_sent_q);
`else
  assign req = start;
`endif

  // tick marks the last clk cycle of an sclk half-period.
  assign tick      = (div_q == DIV_LAST);
  // last_fall marks the sclk fall that ends the final bit.
  assign last_fall = tick && (phase_q == PH_HIGH) && (bitcnt_q == LAST_BIT);

  // State register and all datapath/output registers.
  // NOTE: every register, including the shadow pattern, is reset. This makes
  // the bus come out of reset in a defined state with no X on sdat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_LOW;
      div_q       <= '0;
      bitcnt_q    <= '0;
      shadow_q    <= '0;
      sclk_q      <= 1'b0;
      sclrn_q     <= 1'b0;
      sdat_q      <= 1'b0;
      spen_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEG7_TX_CHANGE_DETECT_EN
      last_sent_q <= '0;
`endif
    end else begin
      // NOTE: use non-blocking assignments so that all registers update
      // together from the old values.
      state_q     <= state_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      bitcnt_q    <= bitcnt_d;
      shadow_q    <= shadow_d;
      sclk_q      <= sclk_d;
      sclrn_q     <= sclrn_d;
      sdat_q      <= sdat_d;
      spen_q      <= spen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEG7_TX_CHANGE_DETECT_EN
      last_sent_q <= last_sent_d;
`endif
    end
  end

  // Next state: leave IDLE on a request; return to IDLE after the final sclk fall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req)       state_d = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values: load on acceptance, then toggle sclk
  // and shift the pattern once per full sclk period.
  always_comb begin
    // NOTE: give every signal a default value first. A path that does not
    // assign a signal would otherwise infer a latch.
    phase_d  = phase_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    shadow_d = shadow_q;
    sclk_d   = sclk_q;
    sclrn_d  = 1'b1;
    sdat_d   = sdat_q;
    spen_d   = spen_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SEG7_TX_CHANGE_DETECT_EN
    last_sent_d = last_sent_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        spen_d = 1'b1;
        sclk_d = 1'b0;
        if (req) begin
          shadow_d = pdata;
          sdat_d   = pdata[WIDTH-1];
          busy_d   = 1'b1;
          spen_d   = 1'b0;
          div_d    = '0;
          bitcnt_d = '0;
          phase_d  = PH_LOW;
`ifdef SEG7_TX_CHANGE_DETECT_EN
          last_sent_d = pdata;
`endif
        end
      end
      ST_SHIFT: begin
        if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (phase_q == PH_LOW) begin
            // The external chain samples sdat on this rising edge.
            sclk_d  = 1'b1;
            phase_d = PH_HIGH;
          end else if (bitcnt_q == LAST_BIT) begin
            sclk_d  = 1'b0;
            phase_d = PH_LOW;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            spen_d  = 1'b1;
          end else begin
            sclk_d   = 1'b0;
            shadow_d = shadow_q << 1;
            sdat_d   = shadow_q[WIDTH-2];
            bitcnt_d = bitcnt_q + CNT_W'(1);
            phase_d  = PH_LOW;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sout = {sclk_q, sclrn_q, sdat_q, spen_q};

endmodule

// File: tb/tb_seg7_serial_tx.sv
// Bench for seg7_serial_tx (WIDTH=64, CLK_DIV=2).
//
// A transaction-level model predicts each acceptance edge and done edge, and
// pushes the expected pattern into a scoreboard queue. A monitor rebuilds
// each word from sdat at the sclk rises and checks it when done pulses.
//
// Build with SEG7_TX_CHANGE_DETECT_EN defined to cover the optional
// change-detect feature.
module tb_seg7_serial_tx;

  localparam int WIDTH   = 64;
  localparam int CLK_DIV = 2;
  localparam int XFER    = 2 * CLK_DIV * WIDTH;
`ifdef SEG7_TX_CHANGE_DETECT_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pdata;
  logic             start;
  logic             busy;
  logic             done;
  logic [3:0]       sout;

  seg7_serial_tx #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .pdata (pdata),
    .start (start),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
    int               done_edge;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               edge_cnt = 0;
  int               n_done = 0;
  int               n_pushed = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference model. At each negedge it decides whether the coming posedge
  // accepts a request. A request is accepted at edge E only if E is later
  // than the previous done edge.
  int               m_free = 0;
  int               m_next;
  logic [WIDTH-1:0] m_last = '0;
  exp_t             m_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_free = 0;
      m_last = '0;
    end else begin
      m_next = edge_cnt + 1;
      if (m_next >= m_free && (start || (CD && pdata != m_last))) begin
        m_e.data      = pdata;
        m_e.acc       = m_next;
        m_e.done_edge = m_next + XFER;
        exp_q.push_back(m_e);
        m_free   = m_next + XFER + 1;
        m_last   = pdata;
        n_pushed++;
      end
    end
  end

  // Monitor: samples the bus at negedge and checks completed transfers
  // against the scoreboard.
  logic             prev_sclk = 1'b0;
  logic [WIDTH-1:0] mon_word = '0;
  int               mon_rises = 0;
  int               mon_busy = 0;
  logic             exp_busy;
  exp_t             got_e;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_sout", {60'd0, sout}, '0);
      check("rst_busy", {63'd0, busy}, '0);
      check("rst_done", {63'd0, done}, '0);
      prev_sclk = 1'b0;
      mon_word  = '0;
      mon_rises = 0;
      mon_busy  = 0;
    end else begin
      exp_busy = (exp_q.size() > 0) && (edge_cnt >= exp_q[0].acc) &&
                 (edge_cnt < exp_q[0].done_edge);
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      if (busy) begin
        mon_busy++;
        check("spen_during_xfer", {63'd0, sout[0]}, '0);
      end else begin
        check("sclk_idle", {63'd0, sout[3]}, '0);
      end
      if (sout[3] && !prev_sclk) begin
        mon_word = {mon_word[WIDTH-2:0], sout[1]};
        mon_rises++;
      end
      prev_sclk = sout[3];
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done pulsed at edge %0d with nothing expected", edge_cnt);
        end else begin
          got_e = exp_q.pop_front();
          check("word",       mon_word, got_e.data);
          check("rises",      WIDTH'(mon_rises), WIDTH'(WIDTH));
          check("busy_cycles", WIDTH'(mon_busy), WIDTH'(XFER));
          check("done_edge",  WIDTH'(edge_cnt), WIDTH'(got_e.done_edge));
        end
        n_done++;
        mon_word  = '0;
        mon_rises = 0;
        mon_busy  = 0;
      end
    end
  end

  task automatic drive(input logic s, input logic [WIDTH-1:0] d);
    @(posedge clk);
    #2;
    start = s;
    pdata = d;
  endtask

  // Waits until the scoreboard is empty and the DUT is idle on two
  // consecutive samples. A timeout counts as a failed check.
  task automatic wait_idle(input int max_cyc);
    int n = 0;
    int quiet = 0;
    while (quiet < 2 && n < max_cyc) begin
      @(negedge clk);
      n++;
      #1;
      if (exp_q.size() == 0 && !busy && !done) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 2) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles (queue=%0d busy=%0b)",
               max_cyc, exp_q.size(), busy);
    end
  endtask

  logic [WIDTH-1:0] p;
  int               base;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pdata = '0;

    // Reset, then the idle bus pattern one edge after release.
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_sout", {60'd0, sout}, {60'd0, 4'b0101});

    // Single transfer of the directed pattern.
    p = 64'hA5A5_0000_FFFF_1234;
    drive(1'b1, p);
    drive(1'b0, p);
    wait_idle(XFER + 20);

    // A start while busy is ignored.
    p = rand64();
    drive(1'b1, p);
    drive(1'b0, p);
    repeat (48) drive(1'b0, p);
    drive(1'b1, '0);
    drive(1'b0, p);
    wait_idle(XFER + 20);

    // Back-to-back transfers with start held high and pdata changing each cycle.
    base = n_done;
    for (int i = 0; i < 3 * (XFER + 1) + 5; i++) drive(1'b1, rand64());
    drive(1'b0, pdata);
    wait_idle(2 * XFER + 20);
    check("b2b_count", WIDTH'(n_done - base >= 3), WIDTH'(1));

    // Abort with rst in the middle of a transfer.
    p = rand64();
    drive(1'b1, p);
    drive(1'b0, p);
    repeat (98) drive(1'b0, p);
    @(posedge clk);
    #2 rst = 1'b1;
    pdata = '0;
    #1;
    check("abort_sout", {60'd0, sout}, '0);
    check("abort_busy", {63'd0, busy}, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    drive(1'b1, 64'h1);
    drive(1'b0, 64'h1);
    wait_idle(XFER + 20);

    // Change detect: with start tied low, a new pdata value starts exactly one
    // transfer when the feature is built in, and none otherwise.
    drive(1'b0, '0);
    wait_idle(XFER + 20);
    base = n_done;
    drive(1'b0, 64'hFF);
    repeat (XFER + 40) @(negedge clk);
    wait_idle(XFER + 20);
    repeat (50) @(negedge clk);
    check("auto_transfers", WIDTH'(n_done - base), CD ? WIDTH'(1) : WIDTH'(0));

    // Random single transfers with random gaps between them.
    for (int i = 0; i < 4; i++) begin
      p = rand64();
      drive(1'b1, p);
      drive(1'b0, p);
      repeat ($urandom_range(0, 5)) drive(1'b0, p);
      wait_idle(XFER + 20);
    end

    check("scoreboard_empty", WIDTH'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
